memory_stage: RTL and testbench

Memory pipeline stage of the microprocessor core. Accepts one memory operation at a time from the execute stage: load, store, call or return. It drives the request signals of the memory I/O multiplexer (main memory, program memory read port, framebuffer, call stack) and owns the call-stack pointer. It returns load data to writeback and return targets to fetch. Because memory reads are synchronous, enables and addresses are held across the read-data cycle, so the output mux in memory I/O selects the matching source.

---
 rtl/memory_stage_pkg.sv | 21 ++
 rtl/memory_stage_call_stack_ptr.sv | 36 +++
 rtl/memory_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_memory_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared encodings and default widths for the memory pipeline stage.
package memory_stage_pkg;
    localparam int ADDR_W_DEF = 17;
    localparam int DATA_W_DEF = 12;
    localparam int PC_W_DEF   = 14;
    localparam int SP_W_DEF   = 8;

    localparam logic [1:0] OP_NOP     = 2'd0;
    localparam logic [1:0] OP_LOAD    = 2'd1;
    localparam logic [1:0] OP_STORE   = 2'd2;
    localparam logic [1:0] OP_CALLRET = 2'd3;

    localparam logic [1:0] SPACE_MAIN = 2'd0;
    localparam logic [1:0] SPACE_PROG = 2'd1;
    localparam logic [1:0] SPACE_FB   = 2'd2;
    localparam logic [1:0] SPACE_RSVD = 2'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
endpackage

// File: rtl/memory_stage_call_stack_ptr.sv
// Call-stack occupancy counter; push/pop are ignored when full/empty.
module call_stack_ptr #(
    parameter int SP_W = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push_i,
    input  logic            pop_i,
    output logic [SP_W:0]   count_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [SP_W-1:0] wr_addr_o,
    output logic [SP_W-1:0] rd_addr_o
);
    logic [SP_W:0] count_q, count_d, count_m1;

    assign full_o    = count_q[SP_W];
    assign empty_o   = (count_q == '0);
    assign count_m1  = count_q - {{SP_W{1'b0}}, 1'b1};
    assign wr_addr_o = count_q[SP_W-1:0];
    assign rd_addr_o = count_m1[SP_W-1:0];
    assign count_o   = count_q;

    always_comb begin
        count_d = count_q;
        if (push_i && !full_o)
            count_d = count_q + {{SP_W{1'b0}}, 1'b1};
        else if (pop_i && !empty_o)
            count_d = count_m1;
    end

    always_ff @(posedge clock) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end
endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: one load/store/call/return at a time, registered
// request strobes held through the synchronous-read cycle.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_W   = PC_W_DEF,
    parameter int SP_W   = SP_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic              in_ret,
    input  logic [1:0]        in_space,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_ret_pc,
    output logic              main_mem_en,
    output logic              prog_mem_en,
    output logic              fb_en,
    output logic              call_stk_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic [SP_W-1:0]   call_stk_addr_out,
    output logic [PC_W-1:0]   call_stk_data_out,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [PC_W-1:0]   call_stk_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic              ret_valid,
    output logic [PC_W-1:0]   ret_pc,
    output logic              err,
    output logic [SP_W:0]     stk_count
);
    logic [1:0]        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic              ret_q, ret_d, fault_q, fault_d, err_q, err_d;
    logic              main_en_q, main_en_d, prog_en_q, prog_en_d;
    logic              fb_en_q, fb_en_d, stk_en_q, stk_en_d, wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d, wb_data_q, wb_data_d;
    logic [SP_W-1:0]   stk_addr_q, stk_addr_d, stk_wr_addr, stk_rd_addr;
    logic [PC_W-1:0]   stk_data_q, stk_data_d, ret_pc_q, ret_pc_d;
    logic              wb_valid_q, wb_valid_d, ret_valid_q, ret_valid_d;
    logic              push, pop, stk_full, stk_empty;

    call_stack_ptr #(.SP_W(SP_W)) u_sp (
        .clock     (clock),
        .reset     (reset),
        .push_i    (push),
        .pop_i     (pop),
        .count_o   (stk_count),
        .full_o    (stk_full),
        .empty_o   (stk_empty),
        .wr_addr_o (stk_wr_addr),
        .rd_addr_o (stk_rd_addr)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ret_d       = ret_q;
        fault_d     = fault_q;
        err_d       = err_q;
        main_en_d   = main_en_q;
        prog_en_d   = prog_en_q;
        fb_en_d     = fb_en_q;
        stk_en_d    = stk_en_q;
        wen_d       = wen_q;
        addr_d      = addr_q;
        data_d      = data_q;
        stk_addr_d  = stk_addr_q;
        stk_data_d  = stk_data_q;
        wb_data_d   = wb_data_q;
        ret_pc_d    = ret_pc_q;
        wb_valid_d  = 1'b0;
        ret_valid_d = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Strobes are set up here so they are registered outputs in ACCESS.
                if (in_valid && in_op != OP_NOP) begin
                    state_d = ST_ACCESS;
                    op_d    = in_op;
                    ret_d   = in_ret;
                    fault_d = 1'b0;
                    addr_d  = in_addr;
                    data_d  = in_data;
                    case (in_op)
                        OP_LOAD: begin
                            case (in_space)
                                SPACE_MAIN: main_en_d = 1'b1;
                                SPACE_PROG: prog_en_d = 1'b1;
                                SPACE_FB:   fb_en_d   = 1'b1;
                                default:    fault_d   = 1'b1;
                            endcase
                        end
                        OP_STORE: begin
                            case (in_space)
                                SPACE_MAIN: begin main_en_d = 1'b1; wen_d = 1'b1; end
                                SPACE_FB:   begin fb_en_d   = 1'b1; wen_d = 1'b1; end
                                default:    fault_d = 1'b1;
                            endcase
                        end
                        default: begin
                            if (!in_ret) begin
                                if (stk_full) fault_d = 1'b1;
                                else begin
                                    stk_en_d   = 1'b1;
                                    wen_d      = 1'b1;
                                    stk_addr_d = stk_wr_addr;
                                    stk_data_d = in_ret_pc;
                                end
                            end else begin
                                if (stk_empty) fault_d = 1'b1;
                                else begin
                                    stk_en_d   = 1'b1;
                                    stk_addr_d = stk_rd_addr;
                                end
                            end
                        end
                    endcase
                    err_d = err_q | fault_d;
                end
            end
            ST_ACCESS: begin
                if (op_q == OP_STORE || (op_q == OP_CALLRET && !ret_q)) begin
                    state_d   = ST_IDLE;
                    main_en_d = 1'b0;
                    prog_en_d = 1'b0;
                    fb_en_d   = 1'b0;
                    stk_en_d  = 1'b0;
                    wen_d     = 1'b0;
                    push      = (op_q == OP_CALLRET) && !fault_q;
                end else begin
                    state_d = ST_WAIT;
                    pop     = (op_q == OP_CALLRET) && !fault_q;
                end
            end
            ST_WAIT: begin
                state_d   = ST_IDLE;
                main_en_d = 1'b0;
                prog_en_d = 1'b0;
                fb_en_d   = 1'b0;
                stk_en_d  = 1'b0;
                if (op_q == OP_LOAD) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = fault_q ? '0 : mem_rdata;
                end else begin
                    ret_valid_d = 1'b1;
                    ret_pc_d    = fault_q ? '0 : call_stk_rdata;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NOP;
            ret_q       <= 1'b0;
            fault_q     <= 1'b0;
            err_q       <= 1'b0;
            main_en_q   <= 1'b0;
            prog_en_q   <= 1'b0;
            fb_en_q     <= 1'b0;
            stk_en_q    <= 1'b0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            stk_addr_q  <= '0;
            stk_data_q  <= '0;
            wb_data_q   <= '0;
            ret_pc_q    <= '0;
            wb_valid_q  <= 1'b0;
            ret_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ret_q       <= ret_d;
            fault_q     <= fault_d;
            err_q       <= err_d;
            main_en_q   <= main_en_d;
            prog_en_q   <= prog_en_d;
            fb_en_q     <= fb_en_d;
            stk_en_q    <= stk_en_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            stk_addr_q  <= stk_addr_d;
            stk_data_q  <= stk_data_d;
            wb_data_q   <= wb_data_d;
            ret_pc_q    <= ret_pc_d;
            wb_valid_q  <= wb_valid_d;
            ret_valid_q <= ret_valid_d;
        end
    end

    assign in_ready          = (state_q == ST_IDLE);
    assign main_mem_en       = main_en_q;
    assign prog_mem_en       = prog_en_q;
    assign fb_en             = fb_en_q;
    assign call_stk_en       = stk_en_q;
    assign mem_wen           = wen_q;
    assign addr_out          = addr_q;
    assign data_out          = data_q;
    assign call_stk_addr_out = stk_addr_q;
    assign call_stk_data_out = stk_data_q;
    assign wb_valid          = wb_valid_q;
    assign wb_data           = wb_data_q;
    assign ret_valid         = ret_valid_q;
    assign ret_pc            = ret_pc_q;
    assign err               = err_q;
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with small memory and call-stack models.
module tb_memory_stage;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic        in_ret;
    logic [1:0]  in_space;
    logic [16:0] in_addr;
    logic [11:0] in_data;
    logic [13:0] in_ret_pc;
    logic        main_mem_en, prog_mem_en, fb_en, call_stk_en, mem_wen;
    logic [16:0] addr_out;
    logic [11:0] data_out;
    logic [7:0]  call_stk_addr_out;
    logic [13:0] call_stk_data_out;
    logic [11:0] mem_rdata;
    logic [13:0] call_stk_rdata;
    logic        wb_valid;
    logic [11:0] wb_data;
    logic        ret_valid;
    logic [13:0] ret_pc;
    logic        err;
    logic [8:0]  stk_count;

    int checks = 0;
    int errors = 0;
    int stk_writes = 0;
    logic [7:0]  mm [0:255];
    logic [13:0] stk [0:255];

    memory_stage dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_ret(in_ret), .in_space(in_space), .in_addr(in_addr),
        .in_data(in_data), .in_ret_pc(in_ret_pc), .main_mem_en(main_mem_en),
        .prog_mem_en(prog_mem_en), .fb_en(fb_en), .call_stk_en(call_stk_en),
        .mem_wen(mem_wen), .addr_out(addr_out), .data_out(data_out),
        .call_stk_addr_out(call_stk_addr_out), .call_stk_data_out(call_stk_data_out),
        .mem_rdata(mem_rdata), .call_stk_rdata(call_stk_rdata), .wb_valid(wb_valid),
        .wb_data(wb_data), .ret_valid(ret_valid), .ret_pc(ret_pc), .err(err),
        .stk_count(stk_count)
    );

    always #5 clock = ~clock;

    // Synchronous-read memory models: address in ACCESS, data visible in WAIT.
    always @(posedge clock) begin
        if (main_mem_en && mem_wen) mm[addr_out[7:0]] <= data_out[7:0];
        if (main_mem_en)      mem_rdata <= {4'h0, mm[addr_out[7:0]]};
        else if (fb_en)       mem_rdata <= 12'hABC;
        else if (prog_mem_en) mem_rdata <= 12'h3C5;
        else                  mem_rdata <= 12'h000;
        if (call_stk_en && mem_wen) begin
            stk[call_stk_addr_out] <= call_stk_data_out;
            stk_writes <= stk_writes + 1;
        end else if (call_stk_en) begin
            call_stk_rdata <= stk[call_stk_addr_out];
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic r, input logic [1:0] sp,
                         input logic [16:0] a, input logic [11:0] d, input logic [13:0] pc);
        in_valid = 1'b1; in_op = op; in_ret = r; in_space = sp;
        in_addr = a; in_data = d; in_ret_pc = pc;
        step();
        in_valid = 1'b0; in_op = 2'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({main_mem_en, prog_mem_en, fb_en, call_stk_en, mem_wen, wb_valid, ret_valid, err} !== 8'h00) begin
            errors++; $display("FAIL reset_flags got %b want 0", {main_mem_en, prog_mem_en, fb_en, call_stk_en, mem_wen, wb_valid, ret_valid, err});
        end
        checks++;
        if (in_ready !== 1'b1 || stk_count !== 9'd0 || addr_out !== 17'd0) begin
            errors++; $display("FAIL reset_state ready %b cnt %0d addr %h want 1 0 0", in_ready, stk_count, addr_out);
        end
    endtask

    task automatic test_store_main();
        issue(2'd2, 1'b0, 2'd0, 17'h00042, 12'h0A5, 14'h0);
        checks++;
        if (main_mem_en !== 1'b1 || mem_wen !== 1'b1 || addr_out !== 17'h00042 || data_out[7:0] !== 8'hA5) begin
            errors++; $display("FAIL store_c1 en %b wen %b addr %h data %h want 1 1 00042 a5", main_mem_en, mem_wen, addr_out, data_out);
        end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL store_ready_c1 got %b want 0", in_ready); end
        step();
        checks++;
        if (main_mem_en !== 1'b0 || mem_wen !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL store_c2 en %b wen %b ready %b err %b want 0 0 1 0", main_mem_en, mem_wen, in_ready, err);
        end
    endtask

    task automatic test_load_fb();
        issue(2'd1, 1'b0, 2'd2, 17'h12C00, 12'h0, 14'h0);
        checks++;
        if (fb_en !== 1'b1 || mem_wen !== 1'b0 || addr_out !== 17'h12C00 || in_ready !== 1'b0) begin
            errors++; $display("FAIL ldfb_c1 fb %b wen %b addr %h rdy %b want 1 0 12c00 0", fb_en, mem_wen, addr_out, in_ready);
        end
        step();
        checks++;
        if (fb_en !== 1'b1 || addr_out !== 17'h12C00 || in_ready !== 1'b0 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL ldfb_c2 fb %b addr %h rdy %b wbv %b want 1 12c00 0 0", fb_en, addr_out, in_ready, wb_valid);
        end
        step();
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 12'hABC || in_ready !== 1'b1 || fb_en !== 1'b0) begin
            errors++; $display("FAIL ldfb_c3 wbv %b data %h rdy %b fb %b want 1 abc 1 0", wb_valid, wb_data, in_ready, fb_en);
        end
        step();
        checks++;
        if (wb_valid !== 1'b0) begin errors++; $display("FAIL ldfb_pulse wbv %b want 0", wb_valid); end
    endtask

    task automatic test_load_main();
        issue(2'd1, 1'b0, 2'd0, 17'h00042, 12'h0, 14'h0);
        step(); step();
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 12'h0A5) begin
            errors++; $display("FAIL ldmain wbv %b data %h want 1 0a5", wb_valid, wb_data);
        end
        step();
    endtask

    task automatic test_call_ret();
        issue(2'd3, 1'b0, 2'd0, 17'h0, 12'h0, 14'h1234);
        checks++;
        if (call_stk_en !== 1'b1 || mem_wen !== 1'b1 || call_stk_addr_out !== 8'd0 || call_stk_data_out !== 14'h1234) begin
            errors++; $display("FAIL call_c1 en %b wen %b addr %h data %h want 1 1 0 1234", call_stk_en, mem_wen, call_stk_addr_out, call_stk_data_out);
        end
        step();
        checks++;
        if (stk_count !== 9'd1 || call_stk_en !== 1'b0) begin
            errors++; $display("FAIL call_cnt got %0d en %b want 1 0", stk_count, call_stk_en);
        end
        issue(2'd3, 1'b1, 2'd0, 17'h0, 12'h0, 14'h0);
        checks++;
        if (call_stk_en !== 1'b1 || mem_wen !== 1'b0 || call_stk_addr_out !== 8'd0) begin
            errors++; $display("FAIL ret_c1 en %b wen %b addr %h want 1 0 0", call_stk_en, mem_wen, call_stk_addr_out);
        end
        step();
        checks++;
        if (stk_count !== 9'd0) begin errors++; $display("FAIL ret_cnt got %0d want 0", stk_count); end
        step();
        checks++;
        if (ret_valid !== 1'b1 || ret_pc !== 14'h1234 || err !== 1'b0) begin
            errors++; $display("FAIL ret_c3 v %b pc %h err %b want 1 1234 0", ret_valid, ret_pc, err);
        end
        step();
    endtask

    task automatic test_ret_empty();
        issue(2'd3, 1'b1, 2'd0, 17'h0, 12'h0, 14'h0);
        checks++;
        if (call_stk_en !== 1'b0 || err !== 1'b1) begin
            errors++; $display("FAIL retempty_c1 en %b err %b want 0 1", call_stk_en, err);
        end
        step(); step();
        checks++;
        if (ret_valid !== 1'b1 || ret_pc !== 14'h0 || stk_count !== 9'd0) begin
            errors++; $display("FAIL retempty_c3 v %b pc %h cnt %0d want 1 0 0", ret_valid, ret_pc, stk_count);
        end
        step();
    endtask

    task automatic test_store_prog();
        do_reset();
        issue(2'd2, 1'b0, 2'd1, 17'h00010, 12'h077, 14'h0);
        checks++;
        if ({main_mem_en, prog_mem_en, fb_en, call_stk_en, mem_wen} !== 5'b0 || err !== 1'b1) begin
            errors++; $display("FAIL stprog strobes %b err %b want 00000 1", {main_mem_en, prog_mem_en, fb_en, call_stk_en, mem_wen}, err);
        end
        step();
    endtask

    task automatic test_stack_full();
        int w0;
        do_reset();
        w0 = stk_writes;
        for (int i = 0; i < 256; i++) begin
            issue(2'd3, 1'b0, 2'd0, 17'h0, 12'h0, 14'h100 + 14'(i));
            step();
        end
        checks++;
        if (stk_count !== 9'd256 || stk_writes - w0 !== 256 || err !== 1'b0) begin
            errors++; $display("FAIL full_fill cnt %0d writes %0d err %b want 256 256 0", stk_count, stk_writes - w0, err);
        end
        issue(2'd3, 1'b0, 2'd0, 17'h0, 12'h0, 14'h3FFF);
        checks++;
        if (call_stk_en !== 1'b0 || err !== 1'b1) begin
            errors++; $display("FAIL full_257 en %b err %b want 0 1", call_stk_en, err);
        end
        step();
        checks++;
        if (stk_count !== 9'd256 || stk_writes - w0 !== 256) begin
            errors++; $display("FAIL full_after cnt %0d writes %0d want 256 256", stk_count, stk_writes - w0);
        end
        issue(2'd3, 1'b1, 2'd0, 17'h0, 12'h0, 14'h0);
        checks++;
        if (call_stk_addr_out !== 8'd255) begin errors++; $display("FAIL full_pop_addr got %0d want 255", call_stk_addr_out); end
        step(); step();
        checks++;
        if (ret_valid !== 1'b1 || ret_pc !== 14'h1FF || stk_count !== 9'd255) begin
            errors++; $display("FAIL full_pop v %b pc %h cnt %0d want 1 1ff 255", ret_valid, ret_pc, stk_count);
        end
        step();
    endtask

    task automatic test_reset_wait();
        do_reset();
        issue(2'd3, 1'b0, 2'd0, 17'h0, 12'h0, 14'h0055);
        step();
        issue(2'd1, 1'b0, 2'd2, 17'h12C00, 12'h0, 14'h0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({main_mem_en, prog_mem_en, fb_en, call_stk_en, mem_wen, wb_valid, ret_valid, err} !== 8'h00 ||
            addr_out !== 17'd0 || wb_data !== 12'd0) begin
            errors++; $display("FAIL rstwait_out flags %b addr %h wbd %h want 0", {main_mem_en, prog_mem_en, fb_en, call_stk_en, mem_wen, wb_valid, ret_valid, err}, addr_out, wb_data);
        end
        checks++;
        if (stk_count !== 9'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rstwait_state cnt %0d rdy %b want 0 1", stk_count, in_ready);
        end
        step();
        checks++;
        if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rstwait_after wbv %b rdy %b want 0 1", wb_valid, in_ready);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin mm[i] = 8'h00; stk[i] = 14'h0; end
        mem_rdata = 12'h0; call_stk_rdata = 14'h0;
        in_valid = 1'b0; in_op = 2'd0; in_ret = 1'b0; in_space = 2'd0;
        in_addr = '0; in_data = '0; in_ret_pc = '0; reset = 1'b1;
        test_reset();
        test_store_main();
        test_load_fb();
        test_load_main();
        test_call_ret();
        test_ret_empty();
        test_store_prog();
        test_stack_full();
        test_reset_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
